// File: rtl/alu_if.sv
// Operand/result bundle between the control sequencer and the ALU execution stage.
// The master side issues ops; the slave side (ALU) returns result, flags and handshake.
interface alu_if #(
  parameter int unsigned DATA_BUS_WIDTH = 8
);
  logic                      start;
  logic [3:0]                op;
  logic [DATA_BUS_WIDTH-1:0] operand_a;
  logic [DATA_BUS_WIDTH-1:0] operand_b;
  logic [DATA_BUS_WIDTH-1:0] result;
  logic [3:0]                flags;
  logic                      busy;
  logic                      done;

  modport master (
    output start, op, operand_a, operand_b,
    input  result, flags, busy, done
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output result, flags, busy, done
  );
endinterface

// File: rtl/alu_unit.sv
// Execution stage: single-cycle ALU ops plus an iterative shift-add multiply.
// All state updates on the falling clock edge to line up with the register file.
module alu_unit #(
  parameter int unsigned DATA_BUS_WIDTH = 8
) (
  input  logic  i_clock,
  input  logic  i_reset,
  alu_if.slave  bus
);

  localparam int unsigned W    = DATA_BUS_WIDTH;
  localparam int unsigned CntW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpAnd   = 4'd2;
  localparam logic [3:0] OpOr    = 4'd3;
  localparam logic [3:0] OpXor   = 4'd4;
  localparam logic [3:0] OpNot   = 4'd5;
  localparam logic [3:0] OpShl   = 4'd6;
  localparam logic [3:0] OpShr   = 4'd7;
  localparam logic [3:0] OpPassB = 4'd8;
  localparam logic [3:0] OpMul   = 4'd9;

  typedef enum logic [0:0] {StIdle, StMulRun} state_e;

  state_e          r_state;
  logic [W-1:0]    r_result;
  logic [3:0]      r_flags;
  logic            r_busy;
  logic            r_done;
  logic [2*W-1:0]  r_a;
  logic [W-1:0]    r_b;
  logic [2*W-1:0]  r_acc;
  logic [CntW-1:0] r_cnt;

  state_e          w_state_next;
  logic [W-1:0]    w_result_next;
  logic [3:0]      w_flags_next;
  logic            w_busy_next;
  logic            w_done_next;
  logic [2*W-1:0]  w_a_next;
  logic [W-1:0]    w_b_next;
  logic [2*W-1:0]  w_acc_next;
  logic [CntW-1:0] w_cnt_next;

  logic [W:0]      w_sum;
  logic [W:0]      w_diff;
  logic [W-1:0]    w_res;
  logic            w_c;
  logic            w_v;
  logic            w_valid;
  logic [2*W-1:0]  w_acc_sum;
  logic [W-1:0]    w_mul_lo;
  logic            w_mul_hi_nz;

  // Single-cycle datapath; w_valid drops for reserved codes so they act as NOPs.
  always_comb begin
    w_sum   = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    w_diff  = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
    w_res   = r_result;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_valid = 1'b1;
    case (bus.op)
      OpAdd: begin
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (bus.operand_a[W-1] == bus.operand_b[W-1]) &&
                (w_sum[W-1] != bus.operand_a[W-1]);
      end
      OpSub: begin
        w_res = w_diff[W-1:0];
        w_c   = w_diff[W];
        w_v   = (bus.operand_a[W-1] != bus.operand_b[W-1]) &&
                (w_diff[W-1] != bus.operand_a[W-1]);
      end
      OpAnd:   w_res = bus.operand_a & bus.operand_b;
      OpOr:    w_res = bus.operand_a | bus.operand_b;
      OpXor:   w_res = bus.operand_a ^ bus.operand_b;
      OpNot:   w_res = ~bus.operand_a;
      OpShl: begin
        w_res = {bus.operand_a[W-2:0], 1'b0};
        w_c   = bus.operand_a[W-1];
      end
      OpShr: begin
        w_res = {1'b0, bus.operand_a[W-1:1]};
        w_c   = bus.operand_a[0];
      end
      OpPassB: w_res = bus.operand_b;
      default: w_valid = 1'b0;
    endcase
  end

  // One shift-add step; on the last step this already holds the full 2W product.
  always_comb begin
    w_acc_sum   = r_acc + (r_b[0] ? r_a : '0);
    w_mul_lo    = w_acc_sum[W-1:0];
    w_mul_hi_nz = |w_acc_sum[2*W-1:W];
  end

  always_comb begin
    w_state_next  = r_state;
    w_result_next = r_result;
    w_flags_next  = r_flags;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    w_a_next      = r_a;
    w_b_next      = r_b;
    w_acc_next    = r_acc;
    w_cnt_next    = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          if (bus.op == OpMul) begin
            w_a_next     = {{W{1'b0}}, bus.operand_a};
            w_b_next     = bus.operand_b;
            w_acc_next   = '0;
            w_cnt_next   = '0;
            w_busy_next  = 1'b1;
            w_state_next = StMulRun;
          end else begin
            w_done_next = 1'b1;
            if (w_valid) begin
              w_result_next = w_res;
              w_flags_next  = {(w_res == '0), w_c, w_res[W-1], w_v};
            end
          end
        end
      end
      StMulRun: begin
        w_acc_next = w_acc_sum;
        w_a_next   = r_a << 1;
        w_b_next   = r_b >> 1;
        w_cnt_next = r_cnt + CntW'(1);
        if (r_cnt == CntLast) begin
          w_result_next = w_mul_lo;
          w_flags_next  = {(w_mul_lo == '0), w_mul_hi_nz, w_mul_lo[W-1], w_mul_hi_nz};
          w_busy_next   = 1'b0;
          w_done_next   = 1'b1;
          w_cnt_next    = '0;
          w_state_next  = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(negedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_result <= '0;
      r_flags  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_result <= w_result_next;
      r_flags  <= w_flags_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
      r_a      <= w_a_next;
      r_b      <= w_b_next;
      r_acc    <= w_acc_next;
      r_cnt    <= w_cnt_next;
    end
  end

  assign bus.result = r_result;
  assign bus.flags  = r_flags;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Execution stage directly downstream of the 4-entry register file.
- Consumes the two register read ports as operands and computes an 8-bit result plus a Z/C/N/V flag nibble.
- The result is written back through the register file's data input.
- Single-cycle ops complete one edge after start. MUL is an iterative shift-add taking DATA_BUS_WIDTH edges. A start/busy/done handshake lets the control sequencer stall.

Parameters:
- DATA_BUS_WIDTH, 8, operand and result width (W); must be ≥2.

Ports:
- clock  in  1  system clock; all state updates on the falling edge, matching the register file.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request; sampled on a falling edge only when busy=0.
- op  in  4  operation code (encoding below).
- operand_a  in  W  first operand (register file read port 1).
- operand_b  in  W  second operand (register file read port 2).
- result  out  W  registered result; holds until the next completed op.
- flags  out  4  registered {Z,C,N,V} (bit3..bit0).
- busy  out  1  high while a MUL is iterating.
- done  out  1  one-cycle pulse marking the edge at which result/flags were updated.

Behaviour:
- Reset values: result=0, flags=0, busy=0, done=0, state=IDLE; internal accumulator and counters also 0.
- Reset asserted mid-MUL aborts the operation: no done pulse, result unchanged from reset value 0.

Op codes:
- 0 ADD: A+B.
- 1 SUB: A-B.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 NOT: ~A.
- 6 SHL: A<<1.
- 7 SHR: logical A>>1.
- 8 PASSB: B.
- 9 MUL: low W bits of A*B, unsigned.
- 10-15 reserved.

State machine, states IDLE and MUL_RUN:
- IDLE, start=0: done<=0, nothing else changes.
- IDLE, start=1, op≠MUL: result and flags loaded at this edge; done<=1 for exactly one cycle. Latency is 1 edge.
- IDLE, start=1, op=MUL: latch a_q=A zero-extended to 2W, b_q=B, acc=0, cnt=0; busy<=1; go to MUL_RUN.
- MUL_RUN, each edge: if b_q[0], acc+=a_q; a_q<<=1; b_q>>=1; cnt++.
- MUL_RUN, on the edge where cnt==W-1: result<=low W of the final acc, flags updated, busy<=0, done<=1, go to IDLE.
- MUL latency: start sampled at edge k, done high after edge k+W; busy high from edge k to edge k+W.
- start while busy=1 is ignored, not queued.
- Operand or op changes during MUL_RUN have no effect, since operands are latched.
- start may be held high: back-to-back single-cycle ops complete every edge, and done stays high continuously.
- Reserved op with start: result and flags unchanged, done still pulses (treated as NOP).

Flags (computed from the W-bit result):
- Z = result==0.
- N = result[W-1].
- ADD: C = carry out of bit W-1; V = (A[W-1]==B[W-1]) && (result[W-1]≠A[W-1]).
- SUB: C = borrow (A<B unsigned); V = (A[W-1]≠B[W-1]) && (result[W-1]≠A[W-1]).
- AND/OR/XOR/NOT/PASSB: C=0, V=0.
- SHL: C=A[W-1], V=0.
- SHR: C=A[0], V=0.
- MUL: C = upper W bits of the 2W product nonzero; V=C.
- Arithmetic wraps modulo 2^W; no saturation.

Test Plan:
- Reset then idle: reset pulse with start=0 for 5 edges -> result=0x00, flags=0, busy=0, done=0.
- ADD overflow: A=0x7F, B=0x01, op=0, start one edge -> next cycle result=0x80, flags Z0 C0 N1 V1, done high exactly one cycle. ADD A=0xFF, B=0x01 -> result=0x00, flags Z1 C1 N0 V0.
- SUB borrow and shifts: SUB A=0x03, B=0x05 -> 0xFE, C=1, N=1. SHL A=0x81 -> 0x02, C=1. SHR A=0x81 -> 0x40, C=1.
- MUL timing: A=0x0C, B=0x0D, op=9 -> busy high 8 cycles, done after edge k+8, result=0x9C, C=0. A=0x10, B=0x10 -> result=0x00, Z=1, C=1, V=1.
- Busy lockout: during MUL, change A/B and pulse start with op=ADD -> ignored; MUL result is correct; exactly one done pulse.
- Reset mid-MUL: assert reset 3 edges into a MUL -> busy=0, done=0, result=0 immediately. A new ADD after reset release completes normally.
